// File: rtl/gate_test_sequencer.sv
// Stimulus/check sequencer for the two-input gate bank: walks all four input
// vectors, compares the eight gate outputs to a golden table, reports results.
// Optional build macro: GATE_SEQ_STOP_ON_FAIL_EN (end the run at the first failing vector).
module gate_test_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] gates_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [5:0] err_count_out,
  output logic [3:0] fail_vec_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  cnt;

  logic [7:0]  golden;
  logic [7:0]  mismatch;
  logic [3:0]  mis_bits;
  logic [5:0]  err_next;
  logic [1:0]  idx_next;
  logic        any_mis;
  logic        last_vec;

  always_comb begin
    golden = {~(idx[1] ^ idx[0]), ~(idx[1] | idx[0]), ~(idx[1] & idx[0]),
              ~idx[0], ~idx[1], idx[1] ^ idx[0], idx[1] | idx[0], idx[1] & idx[0]};
    mismatch = gates_in ^ golden;
    mis_bits = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mis_bits = mis_bits + {3'b000, mismatch[i]};
    end
    err_next = err_count_out + {2'b00, mis_bits};
    any_mis  = |mismatch;
    idx_next = idx + 2'd1;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    last_vec = (idx == 2'd3) || any_mis;
`else
    last_vec = (idx == 2'd3);
`endif
  end

  // Status outputs are resolved on the SAMPLE->DONE edge so they are already
  // valid during the done_out cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      a_out         <= 1'b0;
      b_out         <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      pass_out      <= 1'b0;
      err_count_out <= '0;
      fail_vec_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_out    <= 1'b0;
          b_out    <= 1'b0;
          done_out <= 1'b0;
          busy_out <= 1'b0;
          if (start_in) begin
            err_count_out <= '0;
            fail_vec_out  <= '0;
            pass_out      <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            busy_out      <= 1'b1;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          err_count_out <= err_next;
          if (any_mis) begin
            fail_vec_out[idx] <= 1'b1;
          end
          if (last_vec) begin
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            pass_out <= (err_next == 6'd0);
            state    <= DONE;
          end else begin
            idx   <= idx_next;
            cnt   <= '0;
            a_out <= idx_next[1];
            b_out <= idx_next[0];
            state <= DRIVE;
          end
        end
        DONE: begin
          done_out <= 1'b0;
          pass_out <= (err_count_out == 6'd0);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: a faultable gate bank model drives
// gates_in, and each scenario task checks against hand-computed results.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] gates;
  logic       a_out, b_out, busy_out, done_out, pass_out;
  logic [5:0] err_count_out;
  logic [3:0] fail_vec_out;
  logic [1:0] fault;

  logic       start_min;
  logic [7:0] gates_min;
  logic       a_min, b_min, busy_min, done_min, pass_min;
  logic [5:0] err_min;
  logic [3:0] fail_min;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // fault: 0 healthy, 1 AND stuck-0, 2 XOR/XNOR swapped, 3 NOT-A stuck-0
  always_comb begin
    gates[0] = a_out & b_out;
    gates[1] = a_out | b_out;
    gates[2] = a_out ^ b_out;
    gates[3] = ~a_out;
    gates[4] = ~b_out;
    gates[5] = ~(a_out & b_out);
    gates[6] = ~(a_out | b_out);
    gates[7] = ~(a_out ^ b_out);
    case (fault)
      2'd1: gates[0] = 1'b0;
      2'd2: begin
        gates[2] = ~(a_out ^ b_out);
        gates[7] = a_out ^ b_out;
      end
      2'd3: gates[3] = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    gates_min = {~(a_min ^ b_min), ~(a_min | b_min), ~(a_min & b_min), ~b_min,
                 ~a_min, a_min ^ b_min, a_min | b_min, a_min & b_min};
  end

  gate_test_sequencer #(.DWELL(4)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .gates_in      (gates),
    .a_out         (a_out),
    .b_out         (b_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .pass_out      (pass_out),
    .err_count_out (err_count_out),
    .fail_vec_out  (fail_vec_out)
  );

  gate_test_sequencer #(.DWELL(1)) dut_min (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start_min),
    .gates_in      (gates_min),
    .a_out         (a_min),
    .b_out         (b_min),
    .busy_out      (busy_min),
    .done_out      (done_min),
    .pass_out      (pass_min),
    .err_count_out (err_min),
    .fail_vec_out  (fail_min)
  );

  // Pulses start for one cycle and counts negedges until done_out is seen.
  task automatic run(input bit glitch, output int lat, output logic [7:0] abseq,
                     output logic busy_first, output logic busy_done);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    abseq = '0;
    busy_first = busy_out;
    while (!done_out && lat < 100) begin
      if ((lat % 5) == 2 && lat < 20) abseq[(lat / 5) * 2 +: 2] = {a_out, b_out};
      if (glitch && (lat == 3 || lat == 12)) start = 1'b1;
      if (glitch && (lat == 4 || lat == 13)) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    busy_done = busy_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_min = 1'b0;
    fault = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_out, b_out, busy_out, done_out, pass_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {a_out, b_out, busy_out, done_out, pass_out});
    end
    checks++;
    if ({err_count_out, fail_vec_out} !== 10'b0) begin
      errors++;
      $display("FAIL reset_results: got err=%0d fail=%b expected 0/0000", err_count_out, fail_vec_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    fault = 2'd0;
    run(1'b0, lat, abseq, bf, bd);
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL clean_latency: got %0d expected 20", lat); end
    checks++;
    if (pass_out !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b expected 1", pass_out); end
    checks++;
    if (err_count_out !== 6'd0) begin errors++; $display("FAIL clean_err: got %0d expected 0", err_count_out); end
    checks++;
    if (fail_vec_out !== 4'b0000) begin errors++; $display("FAIL clean_failvec: got %b expected 0000", fail_vec_out); end
    checks++;
    if (abseq !== 8'b11_10_01_00) begin errors++; $display("FAIL clean_ab_seq: got %b expected 11100100", abseq); end
    checks++;
    if (bf !== 1'b1 || bd !== 1'b0) begin
      errors++;
      $display("FAIL clean_busy: got start=%b done=%b expected 1/0", bf, bd);
    end
    @(negedge clk);
    checks++;
    if (done_out !== 1'b0 || pass_out !== 1'b1 || a_out !== 1'b0 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL clean_after_done: got done=%b pass=%b ab=%b%b expected 0 1 00", done_out, pass_out, a_out, b_out);
    end
  endtask

  task automatic check_run(input string name, input int lat, input int exp_lat,
                           input int exp_err, input logic [3:0] exp_fail);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++;
    if (err_count_out !== 6'(exp_err)) begin errors++; $display("FAIL %s_err: got %0d expected %0d", name, err_count_out, exp_err); end
    checks++;
    if (fail_vec_out !== exp_fail) begin errors++; $display("FAIL %s_failvec: got %b expected %b", name, fail_vec_out, exp_fail); end
    checks++;
    if (pass_out !== (exp_err == 0)) begin errors++; $display("FAIL %s_pass: got %b expected %b", name, pass_out, exp_err == 0); end
  endtask

  task automatic test_and_stuck();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    fault = 2'd1;
    run(1'b0, lat, abseq, bf, bd);
    check_run("and_stuck", lat, 20, 1, 4'b1000);
  endtask

  task automatic test_xor_swap();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    fault = 2'd2;
    run(1'b0, lat, abseq, bf, bd);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check_run("xor_swap", lat, 5, 2, 4'b0001);
`else
    check_run("xor_swap", lat, 20, 8, 4'b1111);
`endif
  endtask

  task automatic test_nota_stuck();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    fault = 2'd3;
    run(1'b0, lat, abseq, bf, bd);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check_run("nota_stuck", lat, 5, 1, 4'b0001);
`else
    check_run("nota_stuck", lat, 20, 2, 4'b0011);
`endif
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    int extra_done;
    fault = 2'd1;
    run(1'b1, lat, abseq, bf, bd);
    check_run("busy_start", lat, 20, 1, 4'b1000);
    extra_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_out || busy_out) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin errors++; $display("FAIL busy_start_rerun: got %0d active cycles expected 0", extra_done); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [7:0] abseq;
    logic bf, bd;
    int seen_done;
    fault = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy_out); end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_out, b_out, busy_out, done_out, pass_out, err_count_out, fail_vec_out} !== 15'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got ab=%b%b busy=%b done=%b pass=%b err=%0d fail=%b expected all 0",
               a_out, b_out, busy_out, done_out, pass_out, err_count_out, fail_vec_out);
    end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_out) seen_done++;
    end
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_out || busy_out) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done); end
    run(1'b0, lat, abseq, bf, bd);
    check_run("after_rst", lat, 20, 0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int gap;
    int guard;
    fault = 2'd0;
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    while (!done_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    gap = 0;
    @(negedge clk);
    gap++;
    while (!done_out && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    checks++;
    if (gap !== 22) begin errors++; $display("FAIL back_to_back_gap: got %0d expected 22", gap); end
    checks++;
    if (pass_out !== 1'b1) begin errors++; $display("FAIL back_to_back_pass: got %b expected 1", pass_out); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_min_dwell();
    int lat;
    @(negedge clk);
    start_min = 1'b1;
    @(negedge clk);
    start_min = 1'b0;
    lat = 0;
    while (!done_min && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL min_dwell_latency: got %0d expected 8", lat); end
    checks++;
    if (pass_min !== 1'b1 || err_min !== 6'd0 || fail_min !== 4'b0000) begin
      errors++;
      $display("FAIL min_dwell_result: got pass=%b err=%0d fail=%b expected 1/0/0000", pass_min, err_min, fail_min);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_and_stuck();
    test_xor_swap();
    test_nota_stuck();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_min_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-checking stimulus/check stage for the two-input gate bank. It drives the bank's `a_in`/`b_in` through all four input combinations and holds each for a programmable dwell. It then samples the bank's eight outputs and compares them against an internally computed golden truth table. It reports a per-vector fail map, a bit-error count and pass/done status through a start/done handshake.

## Interface
- `DWELL`, default 4: number of cycles each vector is driven before sampling; legal range 1..255.
- `clk_in` input 1: clock; all state updates on the rising edge.
- `rst_in` input 1: asynchronous, active-high reset.
- `start_in` input 1: begins a run when sampled high in IDLE; ignored in all other states.
- `gates_in` input 8: gate bank outputs, in bit order 0 AND, 1 OR, 2 XOR, 3 NOT-A, 4 NOT-B, 5 NAND, 6 NOR, 7 XNOR.
- `a_out` output 1: drives the gate bank's `a_in`.
- `b_out` output 1: drives the gate bank's `b_in`.
- `busy_out` output 1: high in DRIVE and SAMPLE.
- `done_out` output 1: one-cycle pulse at the end of a run.
- `pass_out` output 1: high if the last completed run had zero mismatches; held until the next start.
- `err_count_out` output 6: total mismatching bits over the run, 0..32; held.
- `fail_vec_out` output 4: bit i set if vector i had any mismatch; held.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE with index 0 and dwell counter 0.
- Vector index `idx` runs 0..3. `a_out = idx[1]`, `b_out = idx[0]`.
- Golden table is computed from `idx`: {~(a^b), ~(a|b), ~(a&b), ~b, ~a, a^b, a|b, a&b}, MSB to LSB.
- States and transitions:
  - IDLE: `a_out`/`b_out` are 0. If `start_in`=1, clear `err_count_out`, `fail_vec_out` and `pass_out`, set `idx`=0 and the counter to 0, and go to DRIVE.
  - DRIVE: increment the counter each cycle. When the counter reaches `DWELL-1`, go to SAMPLE.
  - SAMPLE: compute `m = gates_in ^ golden`. Add popcount(`m`) to `err_count_out` and set `fail_vec_out[idx]` if `m`≠0. If `idx`=3, go to DONE. Otherwise increment `idx`, clear the counter and return to DRIVE.
  - DONE: `done_out`=1 for this cycle. Set `pass_out` = (`err_count_out`==0) and return to IDLE.
- `a_out`/`b_out` stay at the current vector through SAMPLE. They return to 0 in DONE and IDLE.
- Arithmetic: `err_count_out` is 6 bits. The maximum is 4×8=32, so the count never saturates or wraps.
- `start_in` held high continuously starts a new run on the cycle after DONE, because IDLE lasts at least one cycle.
- An asynchronous reset mid-run aborts immediately. All outputs go to 0, and no `done_out` pulse is produced.

## Timing
- A start sampled at edge E0 enters DRIVE at E0.
- Each vector occupies `DWELL`+1 cycles: DWELL cycles in DRIVE plus 1 in SAMPLE.
- `done_out` is high during the cycle following edge E0+4·(`DWELL`+1). With DWELL=4, that is 20 edges after start.
- `gates_in` is sampled `DWELL` cycles after the vector was applied. The gate bank is combinational, so DWELL ≥ 1 is sufficient.
- `pass_out`, `err_count_out` and `fail_vec_out` are valid from the `done_out` cycle onward. They are stable until the next accepted start.
- `busy_out` rises one cycle after the start edge and falls in the `done_out` cycle.

## Configuration
- `GATE_SEQ_STOP_ON_FAIL_EN`, defined: a SAMPLE with `m`≠0 goes directly to DONE. The remaining vectors are not driven and their `fail_vec_out` bits stay 0.
- `GATE_SEQ_STOP_ON_FAIL_EN`, undefined: all four vectors always run, regardless of mismatches.

## Test plan
- Correct gate bank, DWELL=4, pulse start → `done_out` 20 cycles later; `pass_out`=1, `err_count_out`=0, `fail_vec_out`=4'b0000; `a_out`/`b_out` sequence 00,01,10,11.
- AND output stuck at 0 → `err_count_out`=1, `fail_vec_out`=4'b1000, `pass_out`=0.
- XOR and XNOR swapped → `err_count_out`=8, `fail_vec_out`=4'b1111.
- `GATE_SEQ_STOP_ON_FAIL_EN` defined, NOT-A stuck at 0 → fails on vector 0; `done_out` 5 cycles after start; `fail_vec_out`=4'b0001, `err_count_out`=1.
- `start_in` pulsed while `busy_out`=1 → ignored; results identical to a single run.
- `rst_in` asserted at cycle 7 of a run → all outputs 0 immediately with no `done_out`; a new start then completes normally in 20 cycles.
